// File: rtl/cmd_sequencer.sv
// ============================================================================
//  Module   : cmd_sequencer
//  Purpose  : Buffers host (func, Data) commands in a small FIFO and issues
//             them to the tri-state bus datapath, holding each opcode for its
//             controller length and inserting one NOP gap between commands.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_func,
  input  logic [7:0]               in_data,
  output logic [2:0]               func,
  output logic [7:0]               Data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  localparam logic [2:0] c_NOP  = 3'b000;
  localparam logic [2:0] c_SWAP = 3'b111;

  logic [2:0]      r_mem_func [DEPTH];
  logic [7:0]      r_mem_data [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_level;

  logic [1:0]      r_state;
  logic [1:0]      r_cnt;
  logic [2:0]      r_func;
  logic [7:0]      r_data;
  logic            r_busy;

  logic [1:0]      w_state_nxt;
  logic [1:0]      w_cnt_nxt;
  logic [2:0]      w_func_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_push;
  logic            w_pop;
  logic [2:0]      w_head_func;
  logic [7:0]      w_head_data;

  // Full check looks only at the current level, so a same-edge pop never
  // frees a slot for the push on that edge.
  assign in_ready    = (r_level != c_FULL);
  // NOP commands complete the handshake but are never stored.
  assign w_push      = in_valid & in_ready & (in_func != c_NOP);
  assign w_head_func = r_mem_func[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];

  assign func  = r_func;
  assign Data  = r_data;
  assign busy  = r_busy;
  assign level = r_level;

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem_func[r_wptr] <= in_func;
      r_mem_data[r_wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Sequencer state register with registered datapath outputs.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= 2'd0;
      r_func  <= c_NOP;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_func  <= w_func_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != c_IDLE);
    end
  end

  // Next-state: pop only from IDLE or GAP, count down the hold in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      c_IDLE, c_GAP: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = c_ISSUE;
          w_cnt_nxt   = (w_head_func == c_SWAP) ? 2'd2 : 2'd0;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end
      c_ISSUE: begin
        if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;
        else               w_state_nxt = c_GAP;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output values: load the head on a pop, clear to NOP when a hold ends.
  always_comb begin
    w_func_nxt = r_func;
    w_data_nxt = r_data;
    case (r_state)
      c_IDLE, c_GAP: begin
        if (w_pop) begin
          w_func_nxt = w_head_func;
          w_data_nxt = w_head_data;
        end else begin
          w_func_nxt = c_NOP;
          w_data_nxt = 8'h00;
        end
      end
      c_ISSUE: begin
        if (r_cnt == 2'd0) begin
          w_func_nxt = c_NOP;
          w_data_nxt = 8'h00;
        end
      end
      default: begin
        w_func_nxt = c_NOP;
        w_data_nxt = 8'h00;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_cmd_sequencer
//  Purpose  : Self-checking bench for cmd_sequencer: queue-based reference
//             model compared every cycle, plus literal directed sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          Clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_func = 3'd0;
  logic [7:0]    in_data = 8'd0;
  logic [2:0]    func;
  logic [7:0]    Data;
  logic          busy;
  logic [LW-1:0] level;

  cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_func  (in_func),
    .in_data  (in_data),
    .func     (func),
    .Data     (Data),
    .busy     (busy),
    .level    (level)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of stored commands; m_left counts the command cycles still to be
  // shown on func (0 means the next edge may start a new command).
  logic [10:0] m_q[$];
  int          m_left = 0;
  logic [2:0]  m_func = 3'd0;
  logic [7:0]  m_data = 8'd0;
  logic        m_busy = 1'b0;

  always @(posedge Clock or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_left = 0;
      m_func = 3'd0;
      m_data = 8'd0;
      m_busy = 1'b0;
    end else begin
      logic        do_push;
      logic [10:0] head;
      do_push = in_valid && (m_q.size() != DEPTH) && (in_func != 3'd0);
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else if (m_left == 1) begin
        m_left = 0;
        m_func = 3'd0;
        m_data = 8'd0;
        m_busy = 1'b1;
      end else if (m_q.size() != 0) begin
        head   = m_q.pop_front();
        m_func = head[10:8];
        m_data = head[7:0];
        m_left = (head[10:8] == 3'b111) ? 3 : 1;
        m_busy = 1'b1;
      end else begin
        m_func = 3'd0;
        m_data = 8'd0;
        m_busy = 1'b0;
      end
      if (do_push) m_q.push_back({in_func, in_data});
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge Clock) begin
    if (reset) begin
      check("func",     32'(func),     32'(m_func));
      check("Data",     32'(Data),     32'(m_data));
      check("busy",     32'(busy),     32'(m_busy));
      check("level",    32'(level),    32'(m_q.size()));
      check("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    end
  end

  // ---------------- directed sequences ----------------
  logic [2:0] d_func [8];
  logic [7:0] d_data [8];
  logic [2:0] tr_func [16];
  logic [7:0] tr_data [16];
  logic       tr_busy [16];
  logic [LW-1:0] tr_level [16];

  int bb_func [13] = '{0, 0, 1, 0, 4, 0, 3, 0, 7, 7, 7, 0, 0};
  int sw_func [8]  = '{0, 0, 7, 7, 7, 0, 0, 0};

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_func  = 3'd0;
    in_data  = 8'd0;
  endtask

  task automatic run_directed(input int ncmd, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clock);
      tr_func[c]  = func;
      tr_data[c]  = Data;
      tr_busy[c]  = busy;
      tr_level[c] = level;
      if (c < ncmd) begin
        in_valid = 1'b1;
        in_func  = d_func[c];
        in_data  = d_data[c];
      end else begin
        idle_inputs();
      end
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    idle_inputs();
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge Clock);
      if (m_q.size() == 0 && m_left == 0 && !busy) done = 1'b1;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    logic seen_full;
    logic got_swap;

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      in_valid = 1'($urandom_range(0, 1));
      in_func  = 3'($urandom_range(0, 7));
      in_data  = 8'($urandom_range(0, 255));
    end
    @(negedge Clock);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_func",  32'(func),     32'd0);
    check("rst_data",  32'(Data),     32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_level", 32'(level),    32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Single load.
    d_func[0] = 3'b001; d_data[0] = 8'hA5;
    run_directed(1, 5);
    check("ld_func_k",    32'(tr_func[1]), 32'd0);
    check("ld_func_k1",   32'(tr_func[2]), 32'd1);
    check("ld_data_k1",   32'(tr_data[2]), 32'hA5);
    check("ld_busy_k1",   32'(tr_busy[2]), 32'd1);
    check("ld_func_k2",   32'(tr_func[3]), 32'd0);
    check("ld_data_k2",   32'(tr_data[3]), 32'd0);
    check("ld_busy_gap",  32'(tr_busy[3]), 32'd1);
    check("ld_busy_idle", 32'(tr_busy[4]), 32'd0);
    drain();

    // SWAP hold.
    d_func[0] = 3'b111; d_data[0] = 8'h00;
    run_directed(1, 8);
    for (int c = 0; c < 8; c++) check($sformatf("swap_func[%0d]", c), 32'(tr_func[c]), 32'(sw_func[c]));
    check("swap_busy_gap",  32'(tr_busy[5]), 32'd1);
    check("swap_busy_idle", 32'(tr_busy[6]), 32'd0);
    drain();

    // Back-to-back: LD1 3C, MOV R1->R2, LD3 FF, SWAP.
    d_func[0] = 3'b001; d_data[0] = 8'h3C;
    d_func[1] = 3'b100; d_data[1] = 8'h12;
    d_func[2] = 3'b011; d_data[2] = 8'hFF;
    d_func[3] = 3'b111; d_data[3] = 8'h00;
    run_directed(4, 13);
    for (int c = 0; c < 13; c++) check($sformatf("b2b_func[%0d]", c), 32'(tr_func[c]), 32'(bb_func[c]));
    check("b2b_data_ld1", 32'(tr_data[2]), 32'h3C);
    check("b2b_data_ld3", 32'(tr_data[6]), 32'hFF);
    drain();

    // NOP filtering between two loads.
    d_func[0] = 3'b001; d_data[0] = 8'h11;
    d_func[1] = 3'b000; d_data[1] = 8'h77;
    d_func[2] = 3'b010; d_data[2] = 8'h22;
    run_directed(3, 8);
    check("nop_func_ld1",  32'(tr_func[2]),  32'd1);
    check("nop_level",     32'(tr_level[2]), 32'd0);
    check("nop_func_gap",  32'(tr_func[3]),  32'd0);
    check("nop_level_ld2", 32'(tr_level[3]), 32'd1);
    check("nop_func_ld2",  32'(tr_func[4]),  32'd2);
    check("nop_data_ld2",  32'(tr_data[4]),  32'h22);
    check("nop_func_end",  32'(tr_func[5]),  32'd0);
    check("nop_func_idle", 32'(tr_func[6]),  32'd0);
    drain();

    // Full / wrap: keep in_valid high while commands issue.
    seen_full = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (!in_ready) seen_full = 1'b1;
      in_valid = 1'b1;
      in_func  = 3'($urandom_range(1, 7));
      in_data  = 8'($urandom_range(0, 255));
    end
    check("full_seen", 32'(seen_full), 32'd1);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      in_valid = ($urandom_range(0, 99) < 60);
      in_func  = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      in_data  = 8'($urandom_range(0, 255));
    end
    drain();

    // Asynchronous reset in the middle of a SWAP with a command queued.
    d_func[0] = 3'b111; d_data[0] = 8'h00;
    d_func[1] = 3'b001; d_data[1] = 8'h5A;
    run_directed(2, 3);
    got_swap = 1'b0;
    for (int i = 0; i < 10 && !got_swap; i++) begin
      if (func == 3'b111) got_swap = 1'b1;
      else @(negedge Clock);
    end
    check("swap_timeout", 32'(got_swap), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_func",  32'(func),     32'd0);
    check("arst_data",  32'(Data),     32'd0);
    check("arst_busy",  32'(busy),     32'd0);
    check("arst_level", 32'(level),    32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    @(negedge Clock);
    @(negedge Clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge Clock);
    check("post_rst_func", 32'(func), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
